// File: rtl/alu_share_ctrl.sv
// Shares one alu_top between two requesters: round-robin grant, operand capture,
// fixed-latency wait, then a valid/ready response tagged with the requester id.
module alu_share_ctrl #(
  parameter int N       = 4,
  parameter int ALU_LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*N-1:0] req_op1,
  input  logic [2*N-1:0] req_op2,
  input  logic [2*N-1:0] req_sel,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [2*N-1:0] rsp_result,
  output logic [N-1:0]   alu_operand1,
  output logic [N-1:0]   alu_operand2,
  output logic [N-1:0]   alu_select,
  input  logic [2*N-1:0] alu_result,
  output logic           busy
);

  // Handshakes: a request transfers on a rising edge where req_valid[i] & req_ready[i];
  // a response transfers on a rising edge where rsp_valid & rsp_ready. Valid never
  // waits on ready; the response payload is held stable while rsp_valid is high.

  localparam int CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          last_grant;
  logic [CW-1:0] cnt;
  logic [1:0]    grant;
  logic          grant_id;

  // Round-robin: on a tie the requester that was not served last wins.
  always_comb begin
    grant    = 2'b00;
    grant_id = 1'b0;
    if (state == IDLE && !reset) begin
      case (req_valid)
        2'b01: begin grant = 2'b01; grant_id = 1'b0; end
        2'b10: begin grant = 2'b10; grant_id = 1'b1; end
        2'b11: begin
          if (last_grant) begin grant = 2'b01; grant_id = 1'b0; end
          else            begin grant = 2'b10; grant_id = 1'b1; end
        end
        default: begin grant = 2'b00; grant_id = 1'b0; end
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant != 2'b00) state_nx = EXEC;
      EXEC:    if (cnt == '0)      state_nx = RESP;
      RESP:    if (rsp_ready)      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      cnt          <= '0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      alu_select   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            alu_operand1 <= grant_id ? req_op1[2*N-1:N] : req_op1[N-1:0];
            alu_operand2 <= grant_id ? req_op2[2*N-1:N] : req_op2[N-1:0];
            alu_select   <= grant_id ? req_sel[2*N-1:N] : req_sel[N-1:0];
            rsp_id       <= grant_id;
            last_grant   <= grant_id;
            cnt          <= CW'(ALU_LAT);
          end
        end
        EXEC: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else           rsp_result <= alu_result;
        end
        default: ;
      endcase
    end
  end

  assign req_ready = grant;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl with a registered one-cycle ALU; directed steps followed
// by random traffic, all checked against a cycle-level reference model.
module tb_alu_share_ctrl;
  localparam int N   = 4;
  localparam int LAT = 1;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*N-1:0] req_op1, req_op2, req_sel;
  logic           rsp_valid, rsp_ready, rsp_id, busy;
  logic [2*N-1:0] rsp_result;
  logic [N-1:0]   alu_operand1, alu_operand2, alu_select;
  logic [2*N-1:0] alu_result;

  alu_share_ctrl #(.N(N), .ALU_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .alu_operand1(alu_operand1),
    .alu_operand2(alu_operand2), .alu_select(alu_select),
    .alu_result(alu_result), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2*N-1:0] alu_fn(logic [N-1:0] a, logic [N-1:0] b, logic [N-1:0] s);
    case (s)
      4'd0:    alu_fn = {4'd0, a} + {4'd0, b};
      4'd1:    alu_fn = {4'd0, a} - {4'd0, b};
      4'd2:    alu_fn = {4'd0, a} * {4'd0, b};
      4'd3:    alu_fn = {4'd0, a & b};
      4'd4:    alu_fn = {4'd0, a | b};
      4'd5:    alu_fn = {4'd0, a ^ b};
      default: alu_fn = {a, b};
    endcase
  endfunction

  always_ff @(posedge clk) alu_result <= alu_fn(alu_operand1, alu_operand2, alu_select);

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: grant phase, cycles since the grant, and an expected-response queue.
  logic            m_idle = 1'b1;
  int              m_age  = 0;
  logic            m_last = 1'b1;
  logic [N-1:0]    m_op1 = '0, m_op2 = '0, m_sel = '0;
  logic [2*N:0]    exp_q[$];

  logic           s_ready_hs;
  logic           s_gid;
  logic           s_rv, s_id, s_busy;
  logic [1:0]     s_ready;
  logic [2*N-1:0] s_res;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] arb(logic [1:0] v, logic last);
    if (v == 2'b01) return 2'b01;
    if (v == 2'b10) return 2'b10;
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [N-1:0] s);
    req_valid[i]       = v;
    req_op1[i*N +: N]  = a;
    req_op2[i*N +: N]  = b;
    req_sel[i*N +: N]  = s;
  endtask

  // One clock cycle: inputs already applied at the preceding falling edge.
  task automatic step();
    logic [1:0] er;
    logic       erv;
    logic       g;
    #1;
    s_ready = req_ready; s_rv = rsp_valid; s_id = rsp_id; s_res = rsp_result; s_busy = busy;
    er  = (!reset && m_idle) ? arb(req_valid, m_last) : 2'b00;
    erv = !m_idle && (m_age >= LAT + 2);
    check("req_ready", 32'(s_ready), 32'(er));
    check("rsp_valid", 32'(s_rv), 32'(erv));
    check("busy", 32'(s_busy), 32'(!m_idle));
    check("alu_operand1", 32'(alu_operand1), 32'(m_op1));
    check("alu_operand2", 32'(alu_operand2), 32'(m_op2));
    check("alu_select", 32'(alu_select), 32'(m_sel));
    if (erv && exp_q.size() > 0) begin
      check("rsp_id", 32'(s_id), 32'(exp_q[0][2*N]));
      check("rsp_result", 32'(s_res), 32'(exp_q[0][2*N-1:0]));
    end
    s_ready_hs = 1'b0;
    s_gid      = 1'b0;
    if (reset) begin
      m_idle = 1'b1; m_last = 1'b1; m_age = 0;
      m_op1 = '0; m_op2 = '0; m_sel = '0;
      exp_q.delete();
    end else if (m_idle) begin
      if (er != 2'b00) begin
        g = er[1];
        m_op1 = req_op1[g*N +: N]; m_op2 = req_op2[g*N +: N]; m_sel = req_sel[g*N +: N];
        exp_q.push_back({g, alu_fn(m_op1, m_op2, m_sel)});
        m_last = g; m_idle = 1'b0; m_age = 1;
        s_ready_hs = 1'b1; s_gid = g;
      end
    end else if (erv && rsp_ready) begin
      void'(exp_q.pop_front());
      m_idle = 1'b1;
    end else begin
      m_age++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    int k;
    req_valid = 2'b00; rsp_ready = 1'b1;
    k = 0;
    do begin step(); k++; end while (s_busy && k < 20);
    check("drain_timeout", 32'(s_busy), 32'd0);
  endtask

  initial begin
    int k, n, hs_cyc[4];
    logic hs_id[4];
    logic [2*N-1:0] held_res;
    logic held_id;

    reset = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
    req_op1 = '0; req_op2 = '0; req_sel = '0;
    @(posedge clk); @(negedge clk);
    step();
    check("reset_ready", 32'(s_ready), 32'd0);
    check("reset_busy", 32'(s_busy), 32'd0);
    reset = 1'b0;
    step();
    check("first_tie_ready", 32'(s_ready), 32'b01);
    drain();

    // Single request from requester 0: 2 + 1 via sel 0.
    set_req(0, 1'b1, 4'd2, 4'd1, 4'd0); set_req(1, 1'b0, 4'd0, 4'd0, 4'd0);
    step();
    check("single_grant", 32'(s_ready), 32'b01);
    req_valid = 2'b00;
    k = 0;
    do begin step(); k++; end while (!s_rv && k < 10);
    check("single_latency", 32'(k), 32'(LAT + 2));
    check("single_id", 32'(s_id), 32'd0);
    check("single_result", 32'(s_res), 32'd3);
    drain();

    // Tie straight after reset: req0 (9-5) goes first, then req1 (12*10).
    reset = 1'b1; step(); reset = 1'b0;
    set_req(0, 1'b1, 4'd9, 4'd5, 4'd1); set_req(1, 1'b1, 4'd12, 4'd10, 4'd2);
    n = 0; k = 0;
    while (n < 2 && k < 30) begin
      step(); k++;
      if (s_ready_hs) req_valid[s_gid] = 1'b0;
      if (s_rv) begin
        check(n == 0 ? "tie_id0" : "tie_id1", 32'(s_id), 32'(n));
        check(n == 0 ? "tie_res0" : "tie_res1", 32'(s_res), n == 0 ? 32'd4 : 32'd120);
        n++;
      end
    end
    check("tie_timeout", 32'(n), 32'd2);
    drain();

    // Both continuously valid: alternating grants, back-to-back issue interval.
    set_req(0, 1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)));
    set_req(1, 1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)));
    n = 0; k = 0;
    while (n < 4 && k < 40) begin
      step(); k++;
      if (s_ready_hs) begin hs_cyc[n] = cyc; hs_id[n] = s_gid; n++; end
    end
    check("rr_count", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("rr_order", 32'(hs_id[i]), 32'(i % 2));
      if (i > 0) check("rr_interval", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'(LAT + 3));
    end
    drain();

    // Backpressure with requester 1 waiting behind the response.
    set_req(0, 1'b1, 4'd6, 4'd3, 4'd2); set_req(1, 1'b0, 4'd1, 4'd1, 4'd0);
    step();
    req_valid = 2'b00; rsp_ready = 1'b0;
    k = 0;
    do begin step(); k++; end while (!s_rv && k < 10);
    check("bp_rsp_seen", 32'(s_rv), 32'd1);
    held_id = s_id; held_res = s_res;
    check("bp_result", 32'(held_res), 32'd18);
    req_valid = 2'b10;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", 32'(s_rv), 32'd1);
      check("bp_hold_id", 32'(s_id), 32'(held_id));
      check("bp_hold_res", 32'(s_res), 32'(held_res));
      check("bp_no_grant", 32'(s_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    step();
    check("bp_pending_grant", 32'(s_ready), 32'b10);
    req_valid = 2'b00;
    drain();

    // Reset in the EXEC cycle of req1 (7,4,sel 3): the op is dropped silently.
    set_req(1, 1'b1, 4'd7, 4'd4, 4'd3);
    step();
    check("abort_grant", 32'(s_ready), 32'b10);
    req_valid = 2'b00; reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("abort_idle", 32'(s_busy), 32'd0);
    check("abort_no_rsp", 32'(s_rv), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_never_rsp", 32'(s_rv), 32'd0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(99) == 0);
      req_valid = 2'($urandom_range(3));
      req_op1   = 8'($urandom); req_op2 = 8'($urandom); req_sel = 8'($urandom);
      rsp_ready = ($urandom_range(9) < 7);
      step();
    end
    reset = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
